ps2_rx_periph: RTL and testbench

- Instruction-driven PS/2 receiver peripheral on the sequencer's output-register bus.
- Responds to the 12-bit instruction word strobed by its `oreg_wen` bit.
- Deserialises PS/2 device frames into an internal FIFO.
- Returns received bytes and status on 8-bit lines wired to sequencer input registers; this is the data path back into the sequencer, opposite to the LED/VGA sinks.

---
 rtl/ps2_rx_periph.sv | 189 ++++++++++++++++++
 tb/tb_ps2_rx_periph.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_periph.sv
// Instruction-driven PS/2 receiver: deserialises device frames into a FIFO
// and returns bytes and status to the sequencer input registers.
module ps2_rx_periph #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_en,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [7:0]  data,
    output logic [7:0]  status,
    output logic        ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, clk_d;
    logic          dat_s1, dat_s2;
    logic          fall;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          enabled;
    logic          overflow, frame_err, parity_err;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;

    logic [3:0] op;
    logic       op_pop, op_clr, op_ena, op_flush;
    logic       dis, run;
    logic       stop_now, par_ok, push_req, tmo;
    logic       frame_set, parity_set;
    logic       can_pop, full, do_push, ovf_set;
    logic       imm_unused;

    assign op       = inst[11:8];
    assign op_pop   = inst_en && (op == 4'h1);
    assign op_clr   = inst_en && (op == 4'h2);
    assign op_ena   = inst_en && (op == 4'h3);
    assign op_flush = inst_en && (op == 4'h4);
    assign imm_unused = ^inst[7:1];

    // Disabling in the same cycle as a fall discards that fall too.
    assign dis  = op_ena && !inst[0];
    assign run  = enabled && !dis;
    assign fall = clk_d && !clk_s2;

    assign stop_now   = run && fall && (state == STOP);
    assign par_ok     = ^{shreg, par_bit};
    assign push_req   = stop_now && dat_s2 && par_ok;
    assign tmo        = run && !fall && (state != IDLE) && (tmo_cnt == TMAX);
    assign frame_set  = (stop_now && !dat_s2) || tmo;
    assign parity_set = stop_now && !par_ok;

    assign can_pop = op_pop && (count != '0);
    assign full    = (count == FULL);
    assign do_push = push_req && !op_flush && (!full || can_pop);
    assign ovf_set = push_req && !op_flush && full && !can_pop;

    always_comb begin
        count_next = count;
        if (op_flush)
            count_next = '0;
        else if (do_push && !can_pop)
            count_next = count + 1'b1;
        else if (!do_push && can_pop)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_d  <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_d  <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tmo_cnt <= '0;
        end else if (!run) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tmo_cnt <= '0;
        end else if (fall) begin
            tmo_cnt <= '0;
            unique case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!dat_s2)
                        state <= DATA;
                end
                DATA: begin
                    shreg   <= {dat_s2, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7)
                        state <= PARITY;
                end
                PARITY: begin
                    par_bit <= dat_s2;
                    state   <= STOP;
                end
                STOP: state <= IDLE;
            endcase
        end else if (state != IDLE) begin
            if (tmo) begin
                state   <= IDLE;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end else begin
            tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enabled    <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (op_ena)
                enabled <= inst[0];
            // A new error in the same cycle as CLRERR must survive.
            overflow   <= (overflow   && !op_clr) || ovf_set;
            frame_err  <= (frame_err  && !op_clr) || frame_set;
            parity_err <= (parity_err && !op_clr) || parity_set;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
            data   <= '0;
        end else begin
            count <= count_next;
            ready <= (count_next != '0);
            if (op_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (can_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    data   <= mem[rd_ptr];
                end
            end
        end
    end

    assign status = {4'b0, enabled, overflow, frame_err, parity_err};

endmodule

// File: tb/tb_ps2_rx_periph.sv
// Directed bench for ps2_rx_periph: frames are bit-banged on the pad
// inputs and every observation goes through chk().
module tb_ps2_rx_periph;

    localparam int HALF = 8;
    localparam int TMO  = 4096;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] inst = '0;
    logic        inst_en = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [7:0]  data;
    logic [7:0]  status;
    logic        ready;

    int errors = 0;
    int checks = 0;

    ps2_rx_periph #(.FIFO_DEPTH(8), .TIMEOUT(TMO)) dut (
        .clock    (clock),
        .reset    (reset),
        .inst     (inst),
        .inst_en  (inst_en),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data     (data),
        .status   (status),
        .ready    (ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    task automatic do_inst(input logic [3:0] op, input logic [7:0] imm);
        @(negedge clock);
        inst    = {op, imm};
        inst_en = 1'b1;
        @(negedge clock);
        inst_en = 1'b0;
        inst    = '0;
    endtask

    // Device drives data while clock is high, then pulls clock low.
    task automatic send_bit(input logic b, input logic pop);
        @(negedge clock);
        ps2_data = b;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        if (pop) begin
            @(negedge clock);
            @(negedge clock);
            inst    = {4'h1, 8'h00};
            inst_en = 1'b1;
            @(negedge clock);
            inst_en = 1'b0;
            inst    = '0;
            repeat (HALF - 3) @(negedge clock);
        end else begin
            repeat (HALF) @(negedge clock);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par,
                              input logic stp, input logic pop);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(b[i], 1'b0);
        send_bit(par, 1'b0);
        send_bit(stp, pop);
        @(negedge clock);
        ps2_data = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, odd_par(b), 1'b1, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_data", data, 8'h00);
        chk("rst_status", status, 8'h00);
        chk("rst_ready", {7'b0, ready}, 8'h00);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        send_good(8'h1C);
        chk("disabled_ignore", {7'b0, ready}, 8'h00);

        do_inst(4'h3, 8'h01);
        chk("enable_status", status, 8'h08);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        chk("rx1_ready", {7'b0, ready}, 8'h01);
        do_inst(4'h1, 8'h00);
        chk("rx1_data", data, 8'h1C);
        chk("rx1_ready_after", {7'b0, ready}, 8'h00);
        chk("rx1_status", status, 8'h08);

        send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
        chk("par_ready", {7'b0, ready}, 8'h00);
        chk("par_status", status, 8'h09);
        do_inst(4'h2, 8'h00);
        chk("clrerr_status", status, 8'h08);

        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        chk("stop_ready", {7'b0, ready}, 8'h00);
        chk("stop_status", status, 8'h0A);
        do_inst(4'h2, 8'h00);

        for (int i = 1; i <= 9; i++)
            send_good(8'(i));
        chk("ovf_status", status, 8'h0C);
        chk("ovf_ready", {7'b0, ready}, 8'h01);
        for (int i = 1; i <= 8; i++) begin
            do_inst(4'h1, 8'h00);
            chk($sformatf("ovf_pop%0d", i), data, 8'(i));
        end
        chk("ovf_empty", {7'b0, ready}, 8'h00);
        do_inst(4'h1, 8'h00);
        chk("pop_empty_data", data, 8'h08);
        do_inst(4'h2, 8'h00);
        chk("ovf_clr", status, 8'h08);

        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            send_bit(1'b1, 1'b0);
        repeat (TMO - 100) @(negedge clock);
        chk("tmo_before", status, 8'h08);
        repeat (200) @(negedge clock);
        chk("tmo_status", status, 8'h0A);
        chk("tmo_ready", {7'b0, ready}, 8'h00);
        send_good(8'h55);
        chk("tmo_next_ready", {7'b0, ready}, 8'h01);
        do_inst(4'h1, 8'h00);
        chk("tmo_next_data", data, 8'h55);
        do_inst(4'h2, 8'h00);

        send_good(8'h11);
        send_frame(8'h22, odd_par(8'h22), 1'b1, 1'b1);
        chk("pp_data", data, 8'h11);
        chk("pp_ready", {7'b0, ready}, 8'h01);
        do_inst(4'h1, 8'h00);
        chk("pp_data2", data, 8'h22);
        chk("pp_ready2", {7'b0, ready}, 8'h00);

        send_good(8'h44);
        send_good(8'h45);
        chk("flush_pre", {7'b0, ready}, 8'h01);
        do_inst(4'h4, 8'h00);
        chk("flush_ready", {7'b0, ready}, 8'h00);
        chk("flush_data", data, 8'h22);

        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            send_bit(1'b0, 1'b0);
        do_inst(4'h3, 8'h00);
        chk("dis_status", status, 8'h00);
        do_inst(4'h3, 8'h01);
        send_good(8'h66);
        chk("reen_ready", {7'b0, ready}, 8'h01);
        chk("reen_status", status, 8'h08);
        do_inst(4'h1, 8'h00);
        chk("reen_data", data, 8'h66);

        send_good(8'h77);
        send_good(8'h78);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mrst_data", data, 8'h00);
        chk("mrst_status", status, 8'h00);
        chk("mrst_ready", {7'b0, ready}, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        send_good(8'h12);
        chk("mrst_ignored", {7'b0, ready}, 8'h00);
        do_inst(4'h3, 8'h01);
        send_good(8'h13);
        chk("mrst_rx_ready", {7'b0, ready}, 8'h01);
        do_inst(4'h1, 8'h00);
        chk("mrst_rx_data", data, 8'h13);
        chk("mrst_rx_empty", {7'b0, ready}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
